// File: rtl/spi_readbyte.sv
// spi_readbyte: SPI mode-0 byte receiver, sclk/mosi/cs_n oversampled on clk.
// SPI_READBYTE_TIMEOUT_EN adds a partial-byte inactivity timeout (timeout_err).
module spi_readbyte #(
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2
`ifdef SPI_READBYTE_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena_read,
  input  logic       cs_n,
  input  logic       sclk,
  input  logic       mosi,
  output logic [7:0] data_out,
  output logic       read_done,
  output logic       busy
`ifdef SPI_READBYTE_TIMEOUT_EN
  ,
  output logic       timeout_err
`endif
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sclk_sh;
  logic [SYNC_STAGES-1:0] r_mosi_sh;
  logic [SYNC_STAGES-1:0] r_csn_sh;
  logic                   r_sclk_prev;
  logic [7:0]             r_sr;
  logic [2:0]             r_cnt;
  logic                   r_pend;

  logic       w_sclk;
  logic       w_mosi;
  logic       w_csn;
  logic       w_rise;
  logic       w_abort;
  logic       w_drop;
  logic [7:0] w_sr_nxt;

  assign w_sclk  = r_sclk_sh[SYNC_STAGES-1];
  assign w_mosi  = r_mosi_sh[SYNC_STAGES-1];
  assign w_csn   = r_csn_sh[SYNC_STAGES-1];
  assign w_rise  = w_sclk & ~r_sclk_prev;
  assign w_abort = ~ena_read | w_csn;
  assign busy    = (r_state == SHIFT) && (r_cnt != 3'd0);

  assign w_sr_nxt = (MSB_FIRST != 0) ? {r_sr[6:0], w_mosi}
                                     : {w_mosi, r_sr[7:1]};

  // mosi shares sclk's delay so the sampled bit lines up with its edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_sh   <= '0;
      r_mosi_sh   <= '0;
      r_csn_sh    <= '1;
      r_sclk_prev <= 1'b0;
    end else begin
      r_sclk_sh   <= {r_sclk_sh[SYNC_STAGES-2:0], sclk};
      r_mosi_sh   <= {r_mosi_sh[SYNC_STAGES-2:0], mosi};
      r_csn_sh    <= {r_csn_sh[SYNC_STAGES-2:0], cs_n};
      r_sclk_prev <= w_sclk;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:  if (ena_read && !w_csn) w_state_nxt = SHIFT;
      SHIFT: if (w_abort) w_state_nxt = IDLE;
    endcase
  end

  // abort outranks a coincident 8th edge; byte lands one cycle after it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr      <= 8'h00;
      r_cnt     <= 3'd0;
      r_pend    <= 1'b0;
      data_out  <= 8'h00;
      read_done <= 1'b0;
    end else begin
      r_pend    <= 1'b0;
      read_done <= r_pend;
      if (r_pend) data_out <= r_sr;
      if (r_state != SHIFT || w_abort || w_drop) begin
        r_cnt <= 3'd0;
      end else if (w_rise) begin
        r_sr   <= w_sr_nxt;
        r_cnt  <= r_cnt + 3'd1;
        r_pend <= (r_cnt == 3'd7);
      end
    end
  end

`ifdef SPI_READBYTE_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] r_to;

  assign w_drop = (r_state == SHIFT) && (r_cnt != 3'd0) &&
                  !w_rise && (r_to == TO_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to        <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= w_drop & ~w_abort;
      if (r_state != SHIFT || w_rise || r_cnt == 3'd0 || w_drop) begin
        r_to <= '0;
      end else begin
        r_to <= r_to + 1'b1;
      end
    end
  end
`else
  assign w_drop = 1'b0;
`endif

endmodule

// File: tb/tb_spi_readbyte.sv
// tb_spi_readbyte: directed bench, MSB-first and LSB-first receivers
// share one SPI bus and are checked against hand-computed bytes.
module tb_spi_readbyte;

  logic       clk;
  logic       rst_n;
  logic       ena_read;
  logic       cs_n;
  logic       sclk;
  logic       mosi;
  logic [7:0] m_data;
  logic       m_done;
  logic       m_busy;
  logic [7:0] l_data;
  logic       l_done;
  logic       l_busy;
`ifdef SPI_READBYTE_TIMEOUT_EN
  logic       m_to;
  logic       l_to;
  int         m_to_cnt = 0;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] m_q[$];
  logic [7:0] l_q[$];
  time        m_t[$];
  time        t_last;

  spi_readbyte #(
    .MSB_FIRST(1),
    .SYNC_STAGES(2)
`ifdef SPI_READBYTE_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(64)
`endif
  ) u_msb (
    .clk(clk),
    .rst_n(rst_n),
    .ena_read(ena_read),
    .cs_n(cs_n),
    .sclk(sclk),
    .mosi(mosi),
    .data_out(m_data),
    .read_done(m_done),
    .busy(m_busy)
`ifdef SPI_READBYTE_TIMEOUT_EN
    ,
    .timeout_err(m_to)
`endif
  );

  spi_readbyte #(
    .MSB_FIRST(0),
    .SYNC_STAGES(2)
`ifdef SPI_READBYTE_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(64)
`endif
  ) u_lsb (
    .clk(clk),
    .rst_n(rst_n),
    .ena_read(ena_read),
    .cs_n(cs_n),
    .sclk(sclk),
    .mosi(mosi),
    .data_out(l_data),
    .read_done(l_done),
    .busy(l_busy)
`ifdef SPI_READBYTE_TIMEOUT_EN
    ,
    .timeout_err(l_to)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (m_done) begin
      m_q.push_back(m_data);
      m_t.push_back($time);
    end
    if (l_done) l_q.push_back(l_data);
`ifdef SPI_READBYTE_TIMEOUT_EN
    if (m_to) m_to_cnt++;
`endif
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] qm(input int i);
    return (i < m_q.size()) ? {24'h0, m_q[i]} : 32'hDEAD;
  endfunction

  function automatic logic [31:0] ql(input int i);
    return (i < l_q.size()) ? {24'h0, l_q[i]} : 32'hDEAD;
  endfunction

  task automatic send_bit(input logic b);
    mosi = b;
    #40 sclk = 1'b1;
    t_last = $time;
    #40 sclk = 1'b0;
  endtask

  // first n bits of v, v[7] first on the wire
  task automatic send_byte(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) send_bit(v[7-i]);
  endtask

  initial begin
    rst_n    = 1'b0;
    ena_read = 1'b1;
    cs_n     = 1'b0;
    sclk     = 1'b0;
    mosi     = 1'b0;
    #20;
    check("rst_data", {24'h0, m_data}, 32'h00);
    check("rst_done", {31'h0, m_done}, 32'h0);
    check("rst_busy", {31'h0, m_busy}, 32'h0);
    #10 rst_n = 1'b1;
    #50;

    // 1: D3 MSB first; LSB receiver sees bit-reversed CB
    send_byte(8'hD3, 1);
    check("t1_busy_mid", {31'h0, m_busy}, 32'h1);
    send_byte(8'hA6, 7);
    check("t1_busy_end", {31'h0, m_busy}, 32'h0);
    #20;
    check("t1_m", qm(0), 32'hD3);
    check("t1_l", ql(0), 32'hCB);
    check("t1_lat", (m_t.size() > 0) ? 32'(m_t[0] - t_last) : 32'hDEAD,
          32'd40);
    #50;

    // 2: back-to-back D3, 2C
    send_byte(8'hD3, 8);
    send_byte(8'h2C, 8);
    #60;
    check("t2_m0", qm(1), 32'hD3);
    check("t2_m1", qm(2), 32'h2C);
    check("t2_l1", ql(2), 32'h34);
    check("t2_gap", (m_t.size() > 2) ? 32'(m_t[2] - m_t[1]) : 32'hDEAD,
          32'd640);

    // 3: partial byte aborted by cs_n
    send_byte(8'hFF, 5);
    cs_n = 1'b1;
    #100;
    check("t3_hold", {24'h0, m_data}, 32'h2C);
    check("t3_busy", {31'h0, m_busy}, 32'h0);
    check("t3_nodone", 32'(m_q.size()), 32'd3);
    cs_n = 1'b0;
    #50;
    send_byte(8'hA5, 8);
    #60;
    check("t3_m", qm(3), 32'hA5);
    check("t3_l", ql(3), 32'hA5);

    // 4: disabled receiver ignores the bus
    ena_read = 1'b0;
    send_byte(8'hFF, 4);
    check("t4_busy", {31'h0, m_busy}, 32'h0);
    send_byte(8'hFF, 4);
    #60;
    check("t4_nodone", 32'(m_q.size()), 32'd4);
    check("t4_hold", {24'h0, m_data}, 32'hA5);
    ena_read = 1'b1;
    #50;

    // 5: reset mid-byte
    send_byte(8'h3C, 3);
    rst_n = 1'b0;
    #20;
    check("t5_rst_m", {24'h0, m_data}, 32'h00);
    check("t5_rst_l", {24'h0, l_data}, 32'h00);
    check("t5_rst_busy", {31'h0, m_busy}, 32'h0);
    rst_n = 1'b1;
    #50;
    send_byte(8'h81, 8);
    #60;
    check("t5_m", qm(4), 32'h81);
    check("t5_cnt", 32'(m_q.size()), 32'd5);

    // 6: stream 1,1,0,0,1,0,1,1 -> D3 LSB first, CB MSB first
    send_byte(8'hCB, 8);
    #60;
    check("t6_l", ql(5), 32'hD3);
    check("t6_m", qm(5), 32'hCB);

`ifdef SPI_READBYTE_TIMEOUT_EN
    send_byte(8'hF0, 4);
    #1000;
    check("to_pulse", 32'(m_to_cnt), 32'd1);
    check("to_busy", {31'h0, m_busy}, 32'h0);
    send_byte(8'h5A, 8);
    #60;
    check("to_m", qm(6), 32'h5A);
    check("to_l", ql(6), 32'h5A);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
